// File: rtl/bit_entry_debouncer.sv
// bit_entry_debouncer: two raw push-buttons -> synchronised, debounced one-cycle bit strobes.
// Define BIT_HISTORY_EN to add an 8-bit history of accepted bits (newest in [0]).
module bit_entry_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       btn0_in,
  input  logic       btn1_in,
  output logic       bit_valid,
  output logic       bit_value,
  output logic       busy,
`ifdef BIT_HISTORY_EN
  output logic       err,
  output logic [7:0] history
`else
  output logic       err
`endif
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync0_q, sync0_d;
  logic [SYNC_STAGES-1:0] sync1_q, sync1_d;
  logic                   s0, s1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cand_q, cand_d;
  logic             bit_valid_q, bit_valid_d;
  logic             bit_value_q, bit_value_d;
  logic             err_q, err_d;
  logic             cand_btn, other_btn;

`ifdef BIT_HISTORY_EN
  logic [7:0] history_q, history_d;
`endif

  // Synchronisers run regardless of ena so the FSM never sees stale samples on resume.
  always_comb begin
    sync0_d = {sync0_q[SYNC_STAGES-2:0], btn0_in};
    sync1_d = {sync1_q[SYNC_STAGES-2:0], btn1_in};
  end

  assign s0        = sync0_q[SYNC_STAGES-1];
  assign s1        = sync1_q[SYNC_STAGES-1];
  assign cand_btn  = cand_q ? s1 : s0;
  assign other_btn = cand_q ? s0 : s1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    bit_valid_d = 1'b0;
    bit_value_d = bit_value_q;
    err_d       = 1'b0;
`ifdef BIT_HISTORY_EN
    history_d   = history_q;
`endif
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (s0 && s1) begin
            err_d   = 1'b1;
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end else if (s0 || s1) begin
            state_d = PRESS_WAIT;
            cand_d  = s1;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (other_btn) begin
            err_d   = 1'b1;
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end else if (!cand_btn) begin
            state_d = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_d     = HELD;
            bit_valid_d = 1'b1;
            bit_value_d = cand_q;
`ifdef BIT_HISTORY_EN
            history_d   = {history_q[6:0], cand_q};
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s0 && !s1) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        RELEASE_WAIT: begin
          // Any bounce during release restarts the quiet window.
          if (s0 || s1) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q     <= '0;
      sync1_q     <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_value_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef BIT_HISTORY_EN
      history_q   <= '0;
`endif
    end else begin
      sync0_q     <= sync0_d;
      sync1_q     <= sync1_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      bit_valid_q <= bit_valid_d;
      bit_value_q <= bit_value_d;
      err_q       <= err_d;
`ifdef BIT_HISTORY_EN
      history_q   <= history_d;
`endif
    end
  end

  assign bit_valid = bit_valid_q;
  assign bit_value = bit_value_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
`ifdef BIT_HISTORY_EN
  assign history   = history_q;
`endif

endmodule
